// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg
//   Shared definitions for the fetch PC unit. It holds the FSM state encoding,
//   the PC width, the RVC/base instruction sizes, the layout of an entry in the
//   in-flight prediction pipe, and small address helpers.
// ---------------------------------------------------------------------------
package fetch_pc_unit_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_STALL    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] SIZE_C = 32'd2;  // compressed (RVC) instruction
  localparam logic [PC_W-1:0] SIZE_W = 32'd4;  // base 32-bit instruction

  // One in-flight prediction. The predicted direction is implied by pred_next.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            is_c;
    logic [PC_W-1:0] pred_next;
  } pred_entry_t;

  // Fetch addresses are halfword aligned, so bit 0 is always cleared.
  function automatic logic [PC_W-1:0] hw_align(input logic [PC_W-1:0] a);
    return a & {{(PC_W-1){1'b1}}, 1'b0};
  endfunction

  function automatic logic [PC_W-1:0] insn_size(input logic is_c);
    return is_c ? SIZE_C : SIZE_W;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pred_pipe.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pred_pipe
//   Shift register of PIPE_DEPTH prediction entries, carrying each fetch's
//   PC, size and predicted next PC from IF down to EX.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (valid bits only)
//     hold_i       freeze all slots
//     flush_i      invalidate every slot (wins over hold_i)
//     push_i       entry for the instruction being fetched this cycle
//     ex_valid_o   EX slot holds a live entry
//     ex_entry_o   EX slot contents
// ---------------------------------------------------------------------------
module fetch_pc_unit_pred_pipe
  import fetch_pc_unit_pkg::*;
#(
  parameter int PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        flush_i,
  input  pred_entry_t push_i,
  output logic        ex_valid_o,
  output pred_entry_t ex_entry_o
);

  logic [PIPE_DEPTH-1:0] vld_q;
  pred_entry_t           ent_q [PIPE_DEPTH];

  // Slot 0 is IF->ID, slot PIPE_DEPTH-1 is the EX slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else if (!hold_i) begin
      vld_q <= {vld_q[PIPE_DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!hold_i) begin
      ent_q[0] <= push_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ent_q[i] <= ent_q[i-1];
      end
    end
  end

  assign ex_valid_o = vld_q[PIPE_DEPTH-1];
  assign ex_entry_o = ent_q[PIPE_DEPTH-1];

endmodule

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage PC generator. It drives the fetch PC to I-mem and to both
//   predictor lookup ports, selects the next PC from the predictor, tracks each
//   prediction down to EX, and redirects and flushes on a mispredict while
//   updating the predictor.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     stall_i                         pipeline hold
//     inst_i                          fetched word (bits[1:0]!=11 -> RVC)
//     pc_o, pred_addr_2_o/_4_o        fetch PC and predictor lookup addresses
//     pred_hit_2/4_i, pred_tgt_2/4_i  predictor results per size path
//     flush_o                         kill IF/ID this cycle
//     ex_valid_i, ex_is_branch_i,
//     ex_taken_i, ex_target_i         resolved outcome in EX
//     upd_miss_o, upd_taken_o,
//     upd_addr_o, upd_target_o        predictor update port
// ---------------------------------------------------------------------------
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] pred_addr_2_o,
  output logic [31:0] pred_addr_4_o,
  input  logic        pred_hit_2_i,
  input  logic        pred_hit_4_i,
  input  logic [31:0] pred_tgt_2_i,
  input  logic [31:0] pred_tgt_4_i,
  output logic        flush_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  output logic        upd_miss_o,
  output logic        upd_taken_o,
  output logic [31:0] upd_addr_o,
  output logic [31:0] upd_target_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] redir_q, redir_d;

  logic        is_c, hit;
  logic [31:0] seq_pc, pred_pc, actual_next, redir_tgt;
  logic        ex_vld, mis_now, take;
  pred_entry_t push_e, ex_e;

  logic unused_inst;
  assign unused_inst = ^inst_i[31:2];

  // IF: next-PC selection from the predictor path matching the fetched size
  assign is_c    = (inst_i[1:0] != 2'b11);
  assign hit     = is_c ? pred_hit_2_i : pred_hit_4_i;
  assign seq_pc  = pc_q + insn_size(is_c);
  assign pred_pc = hit ? hw_align(is_c ? pred_tgt_2_i : pred_tgt_4_i) : seq_pc;

  assign push_e = '{pc: pc_q, is_c: is_c, pred_next: pred_pc};

  fetch_pc_unit_pred_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_pred_pipe (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (stall_i),
    .flush_i    (take),
    .push_i     (push_e),
    .ex_valid_o (ex_vld),
    .ex_entry_o (ex_e)
  );

  // EX: compare the carried prediction with the resolved outcome
  assign actual_next = (ex_is_branch_i & ex_taken_i) ? hw_align(ex_target_i)
                                                     : ex_e.pc + insn_size(ex_e.is_c);
  assign mis_now     = ex_vld & ex_valid_i & (actual_next != ex_e.pred_next);

  // A mispredict seen under stall is parked in pend_q/redir_q so the redirect
  // does not depend on EX still presenting the same outcome once stall drops.
  assign take      = ~stall_i & (mis_now | pend_q);
  assign redir_tgt = pend_q ? redir_q : actual_next;

  always_comb begin
    state_d = S_RUN;
    pc_d    = pc_q;
    pend_d  = pend_q;
    redir_d = redir_q;
    if (take) begin
      state_d = S_REDIRECT;
      pc_d    = redir_tgt;
      pend_d  = 1'b0;
    end else if (stall_i) begin
      state_d = S_STALL;
      if (mis_now && !pend_q) begin
        pend_d  = 1'b1;
        redir_d = actual_next;
      end
    end else begin
      state_d = S_RUN;
      pc_d    = pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    redir_q <= redir_d;
  end

  // The redirect already landed in pc_q; the REDIRECT cycle tells the
  // downstream stages to drop the two wrong-path instructions.
  assign flush_o = (state_q == S_REDIRECT);

  assign pc_o          = pc_q;
  assign pred_addr_2_o = pc_q;
  assign pred_addr_4_o = pc_q;

  assign upd_miss_o   = ex_valid_i & ex_is_branch_i & ~stall_i;
  assign upd_taken_o  = ex_taken_i;
  assign upd_addr_o   = ex_vld ? ex_e.pc : 32'h0;
  assign upd_target_o = hw_align(ex_target_i);

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [31:0] inst_i;
  logic [31:0] pc_o, pred_addr_2_o, pred_addr_4_o;
  logic        pred_hit_2_i, pred_hit_4_i;
  logic [31:0] pred_tgt_2_i, pred_tgt_4_i;
  logic        flush_o;
  logic        ex_valid_i, ex_is_branch_i, ex_taken_i;
  logic [31:0] ex_target_i;
  logic        upd_miss_o, upd_taken_o;
  logic [31:0] upd_addr_o, upd_target_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .PIPE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .inst_i         (inst_i),
    .pc_o           (pc_o),
    .pred_addr_2_o  (pred_addr_2_o),
    .pred_addr_4_o  (pred_addr_4_o),
    .pred_hit_2_i   (pred_hit_2_i),
    .pred_hit_4_i   (pred_hit_4_i),
    .pred_tgt_2_i   (pred_tgt_2_i),
    .pred_tgt_4_i   (pred_tgt_4_i),
    .flush_o        (flush_o),
    .ex_valid_i     (ex_valid_i),
    .ex_is_branch_i (ex_is_branch_i),
    .ex_taken_i     (ex_taken_i),
    .ex_target_i    (ex_target_i),
    .upd_miss_o     (upd_miss_o),
    .upd_taken_o    (upd_taken_o),
    .upd_addr_o     (upd_addr_o),
    .upd_target_o   (upd_target_o)
  );

  // Reference model: the fetch PC plus a queue of the instructions in flight
  // between IF and EX. The oldest one sits in EX once two are in flight.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] size;
    logic [31:0] pnext;
  } ent_t;

  ent_t        inflight[$];
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  bit          m_pend;
  bit          m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic bit ex_live();
    return inflight.size() == 2;
  endfunction

  task automatic check_model();
    chk("pc_o", pc_o, m_pc);
    chk("pred_addr_2_o", pred_addr_2_o, m_pc);
    chk("pred_addr_4_o", pred_addr_4_o, m_pc);
    chk1("flush_o", flush_o, m_flush);
    chk1("upd_miss_o", upd_miss_o, ex_valid_i & ex_is_branch_i & ~stall_i);
    chk1("upd_taken_o", upd_taken_o, ex_taken_i);
    chk("upd_addr_o", upd_addr_o, ex_live() ? inflight[0].pc : 32'h0);
    chk("upd_target_o", upd_target_o, ex_target_i & 32'hFFFF_FFFE);
  endtask

  task automatic model_clock();
    logic [31:0] sz, nxt, actual;
    bit          mis;
    sz  = (inst_i[1:0] != 2'b11) ? 32'd2 : 32'd4;
    if (sz == 32'd2) nxt = pred_hit_2_i ? (pred_tgt_2_i & 32'hFFFF_FFFE) : m_pc + sz;
    else             nxt = pred_hit_4_i ? (pred_tgt_4_i & 32'hFFFF_FFFE) : m_pc + sz;
    mis    = 1'b0;
    actual = 32'h0;
    if (ex_live() && ex_valid_i) begin
      actual = (ex_is_branch_i && ex_taken_i) ? (ex_target_i & 32'hFFFF_FFFE)
                                              : inflight[0].pc + inflight[0].size;
      mis = (actual != inflight[0].pnext);
    end
    if (rst) begin
      m_pc = 32'h0; inflight.delete(); m_pend = 1'b0; m_flush = 1'b0;
    end else if (!stall_i && (mis || m_pend)) begin
      m_pc = m_pend ? m_redir : actual;
      inflight.delete(); m_pend = 1'b0; m_flush = 1'b1;
    end else if (stall_i) begin
      m_flush = 1'b0;
      if (mis && !m_pend) begin m_pend = 1'b1; m_redir = actual; end
    end else begin
      inflight.push_back('{pc: m_pc, size: sz, pnext: nxt});
      if (inflight.size() > 2) void'(inflight.pop_front());
      m_pc = nxt; m_flush = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic br, input logic tk, input logic [31:0] tgt);
    ex_valid_i = v; ex_is_branch_i = br; ex_taken_i = tk; ex_target_i = tgt;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; inst_i = 32'h0000_0013;
    pred_hit_2_i = 1'b0; pred_hit_4_i = 1'b0;
    pred_tgt_2_i = 32'h0; pred_tgt_4_i = 32'h0;
    ex_set(1'b0, 1'b0, 1'b0, 32'h0);
    m_pc = 32'h0; m_redir = 32'h0; m_pend = 1'b0; m_flush = 1'b0;

    // Reset, then sequential 32-bit fetch
    @(negedge clk);
    model_clock();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset pc_o", pc_o, 32'h0);
    chk1("reset flush_o", flush_o, 1'b0);
    chk1("reset upd_miss_o", upd_miss_o, 1'b0);
    chk("reset upd_addr_o", upd_addr_o, 32'h0);
    cyc(); chk("seq pc 4", pc_o, 32'h4);
    cyc(); chk("seq pc 8", pc_o, 32'h8);
    cyc(); chk("seq pc C", pc_o, 32'hC);
    cyc(); chk("seq pc 10", pc_o, 32'h10);

    // Mixed RVC sizes
    inst_i = 32'h0000_0001;
    cyc(); chk("rvc pc 12", pc_o, 32'h12);
    inst_i = 32'h0000_0013;
    cyc(); chk("w32 pc 16", pc_o, 32'h16);

    // Correctly predicted taken branch at 0x20
    pred_hit_4_i = 1'b1; pred_tgt_4_i = 32'h20;
    cyc(); chk("hit pc 20", pc_o, 32'h20);
    pred_tgt_4_i = 32'h100;
    cyc(); chk("taken no bubble", pc_o, 32'h100);
    pred_hit_4_i = 1'b0;
    cyc();
    ex_set(1'b1, 1'b1, 1'b1, 32'h100);
    #1;
    chk1("good upd_miss_o", upd_miss_o, 1'b1);
    chk1("good upd_taken_o", upd_taken_o, 1'b1);
    chk("good upd_addr_o", upd_addr_o, 32'h20);
    cyc();
    ex_set(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("good no flush", flush_o, 1'b0);
    chk("good pc 108", pc_o, 32'h108);

    // Predicted not-taken at 0x40, resolved taken to 0x80
    pred_hit_4_i = 1'b1; pred_tgt_4_i = 32'h40;
    cyc(); pred_hit_4_i = 1'b0;
    chk("pc 40", pc_o, 32'h40);
    cyc(); cyc();
    ex_set(1'b1, 1'b1, 1'b1, 32'h80);
    #1;
    chk1("mis upd_miss_o", upd_miss_o, 1'b1);
    chk("mis upd_addr_o", upd_addr_o, 32'h40);
    chk("mis upd_target_o", upd_target_o, 32'h80);
    cyc();
    ex_set(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("mis flush_o", flush_o, 1'b1);
    chk("mis redirect pc", pc_o, 32'h80);
    cyc();
    chk1("mis flush one cycle", flush_o, 1'b0);
    chk("after redirect pc", pc_o, 32'h84);

    // Mispredict arriving under a 3-cycle stall
    cyc(); cyc();
    stall_i = 1'b1;
    ex_set(1'b1, 1'b1, 1'b1, 32'h200);
    #1;
    chk1("stall upd_miss_o", upd_miss_o, 1'b0);
    chk("stall upd_addr_o", upd_addr_o, 32'h84);
    cyc();
    ex_set(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall hold 1", pc_o, 32'h8C);
    cyc(); chk("stall hold 2", pc_o, 32'h8C);
    cyc(); chk("stall hold 3", pc_o, 32'h8C);
    chk1("stall no flush", flush_o, 1'b0);
    stall_i = 1'b0;
    cyc();
    chk("deferred redirect pc", pc_o, 32'h200);
    chk1("deferred flush_o", flush_o, 1'b1);
    cyc();
    chk1("deferred flush one cycle", flush_o, 1'b0);

    // Reset while in the redirect cycle
    cyc();
    ex_set(1'b1, 1'b1, 1'b1, 32'h300);
    cyc();
    ex_set(1'b0, 1'b0, 1'b0, 32'h0);
    chk1("pre-reset flush_o", flush_o, 1'b1);
    chk("pre-reset pc", pc_o, 32'h300);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("reset mid-redirect pc", pc_o, 32'h0);
    chk1("reset mid-redirect flush", flush_o, 1'b0);
    chk("reset mid-redirect pipe empty", upd_addr_o, 32'h0);
    cyc(); cyc();
    chk("post-reset pc 8", pc_o, 32'h8);

    // Address wrap and odd target alignment
    pred_hit_4_i = 1'b1; pred_tgt_4_i = 32'hFFFF_FFFC;
    cyc(); pred_hit_4_i = 1'b0;
    chk("pc FFFFFFFC", pc_o, 32'hFFFF_FFFC);
    cyc(); chk("wrap 32-bit", pc_o, 32'h0);
    inst_i = 32'h0000_0001; pred_hit_2_i = 1'b1; pred_tgt_2_i = 32'hFFFF_FFFF;
    cyc(); pred_hit_2_i = 1'b0;
    chk("odd target aligned", pc_o, 32'hFFFF_FFFE);
    cyc(); chk("wrap rvc", pc_o, 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      stall_i      = ($urandom_range(0, 4) == 0);
      inst_i       = $urandom;
      pred_hit_2_i = $urandom_range(0, 1) == 1;
      pred_hit_4_i = $urandom_range(0, 1) == 1;
      pred_tgt_2_i = $urandom;
      pred_tgt_4_i = $urandom;
      if (ex_live()) begin
        ex_valid_i = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          // outcome that agrees with the carried prediction
          if (inflight[0].pnext == inflight[0].pc + inflight[0].size)
            ex_set(ex_valid_i, $urandom_range(0, 1) == 1, 1'b0, $urandom);
          else
            ex_set(ex_valid_i, 1'b1, 1'b1, inflight[0].pnext | 32'($urandom_range(0, 1)));
        end else begin
          ex_set(ex_valid_i, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end
      end else begin
        ex_set($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
